// File: rtl/register_file.sv
// rtl/register_file.sv - 4x16 register file with one write port and two registered read ports
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] write_adr,
    input  logic [ADDR_WIDTH-1:0] read_adr1,
    input  logic [ADDR_WIDTH-1:0] read_adr2,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    reg   [DATA_WIDTH-1:0] reg_file   [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] reg_file_d [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] read_data1_q, read_data1_d;
    logic [DATA_WIDTH-1:0] read_data2_q, read_data2_d;

    logic hit1, hit2;

    // A read that targets the entry being written this edge returns the new data.
    assign hit1 = write_en && (read_adr1 == write_adr);
    assign hit2 = write_en && (read_adr2 == write_adr);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_file_d[i] = reg_file[i];
        end
        read_data1_d = read_data1_q;
        read_data2_d = read_data2_q;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_file_d[i] = '0;
            end
            read_data1_d = '0;
            read_data2_d = '0;
        end else begin
            if (write_en) begin
                reg_file_d[write_adr] = write_data;
            end
            if (read_en) begin
                read_data1_d = hit1 ? write_data : reg_file[read_adr1];
                read_data2_d = hit2 ? write_data : reg_file[read_adr2];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_file[i] <= reg_file_d[i];
        end
        read_data1_q <= read_data1_d;
        read_data2_q <= read_data2_d;
    end

    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic        read_en;
    logic [1:0]  write_adr;
    logic [1:0]  read_adr1;
    logic [1:0]  read_adr2;
    logic [15:0] write_data;
    logic [15:0] read_data1;
    logic [15:0] read_data2;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [4];
    logic [15:0] exp1, exp2;

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) uut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_adr  (write_adr),
        .read_adr1  (read_adr1),
        .read_adr2  (read_adr2),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic we, input logic [1:0] wa,
                         input logic [15:0] wd, input logic re,
                         input logic [1:0] a1, input logic [1:0] a2);
        reset      = rst;
        write_en   = we;
        write_adr  = wa;
        write_data = wd;
        read_en    = re;
        read_adr1  = a1;
        read_adr2  = a2;
    endtask

    // Advance one edge and apply the architectural rules: reset clears everything,
    // otherwise the write lands first and enabled reads see the updated contents.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 4; i++) model[i] = 16'h0;
            exp1 = 16'h0;
            exp2 = 16'h0;
        end else begin
            if (write_en) model[write_adr] = write_data;
            if (read_en) begin
                exp1 = model[read_adr1];
                exp2 = model[read_adr2];
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 2'd1, 16'hBEEF, 1'b1, 2'd1, 2'd1);
        cycle();
        checks++;
        if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h expected 0000/0000", read_data1, read_data2);
        end
    endtask

    task automatic test_preload_read();
        drive(1'b1, 1'b1, 2'd0, 16'hCCCC, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b1, 2'd2, 16'hF0F0, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b1, 2'd3, 16'h8E38, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd1); cycle();
        checks++;
        if (read_data1 !== 16'hCCCC || read_data2 !== 16'hAAAA) begin
            errors++;
            $display("FAIL preload_read: got %h/%h expected CCCC/AAAA", read_data1, read_data2);
        end
    endtask

    task automatic test_read_hold();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd2, 2'd3);
            cycle();
            checks++;
            if (read_data1 !== 16'hCCCC || read_data2 !== 16'hAAAA) begin
                errors++;
                $display("FAIL read_hold: cycle %0d got %h/%h expected CCCC/AAAA", i, read_data1, read_data2);
            end
        end
    endtask

    task automatic test_write();
        logic [15:0] want [4];
        want[0] = 16'hCCCC; want[1] = 16'hAAAA; want[2] = 16'hFFFF; want[3] = 16'h8E38;
        drive(1'b1, 1'b1, 2'd2, 16'hFFFF, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd2); cycle();
        checks++;
        if (read_data1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL write_readback: got %h expected FFFF", read_data1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'(i), 2'(3 - i)); cycle();
            checks++;
            if (read_data1 !== want[i] || read_data2 !== want[3 - i]) begin
                errors++;
                $display("FAIL write_isolation: entry %0d got %h/%h expected %h/%h",
                         i, read_data1, read_data2, want[i], want[3 - i]);
            end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 2'd3, 16'h1234, 1'b1, 2'd3, 2'd0); cycle();
        checks++;
        if (read_data1 !== 16'h1234 || read_data2 !== 16'hCCCC) begin
            errors++;
            $display("FAIL bypass: got %h/%h expected 1234/CCCC", read_data1, read_data2);
        end
        drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 2'd3); cycle();
        checks++;
        if (read_data2 !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_stored: got %h expected 1234", read_data2);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 2'd2, 16'h7777, 1'b1, 2'd2, 2'd3); cycle();
        checks++;
        if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h/%h expected 0000/0000", read_data1, read_data2);
        end
        for (int i = 0; i < 4; i += 2) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'(i), 2'(i + 1)); cycle();
            checks++;
            if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin
                errors++;
                $display("FAIL reset_mid_contents: entries %0d/%0d got %h/%h expected 0000/0000",
                         i, i + 1, read_data1, read_data2);
            end
        end
    endtask

    task automatic test_same_addr();
        drive(1'b1, 1'b1, 2'd1, 16'h5A5A, 1'b0, 2'd0, 2'd0); cycle();
        drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd1); cycle();
        checks++;
        if (read_data1 !== 16'h5A5A || read_data2 !== 16'h5A5A) begin
            errors++;
            $display("FAIL same_addr: got %h/%h expected 5A5A/5A5A", read_data1, read_data2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) != 0), 1'($urandom), 2'($urandom), 16'($urandom),
                  1'($urandom), 2'($urandom), 2'($urandom));
            cycle();
            checks++;
            if (read_data1 !== exp1 || read_data2 !== exp2) begin
                errors++;
                $display("FAIL random: iter %0d got %h/%h expected %h/%h",
                         n, read_data1, read_data2, exp1, exp2);
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0);
        test_reset();
        test_preload_read();
        test_read_hold();
        test_write();
        test_bypass();
        test_reset_mid();
        test_same_addr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
